// File: rtl/trap_ctrl.sv
// trap_ctrl: pipeline flush/stall/redirect control with multi-cycle trap-entry CSR save FSM
module trap_ctrl #(
  parameter logic [31:0] MCAUSE_ECALL  = 32'd11,
  parameter logic [31:0] MCAUSE_EBREAK = 32'd3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stallreq_i,
  input  logic        ecall_exce_i,
  input  logic        ebreak_exce_i,
  input  logic        mret_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic [31:0] instr_addr_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] mstatus_i,
  output logic        csr_we_o,
  output logic [11:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        stall_o,
  output logic        refresh_pip_o,
  output logic        redirect_o,
  output logic [31:0] redirect_addr_o,
  output logic        trap_busy_o
);
  typedef enum logic [2:0] {IDLE, SAVE_MEPC, SAVE_MCAUSE, SAVE_MSTATUS, REDIRECT} state_t;
  state_t      state_q;
  logic [31:0] epc_q, cause_q, mstatus_q;
  logic        idle, exc, trap_go, mret_go, jump_go, s_mepc, s_mcause, s_mstatus, s_redir, save;
  logic [31:0] trap_mstatus, mret_mstatus;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      epc_q     <= '0;
      cause_q   <= '0;
      mstatus_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (ecall_exce_i || ebreak_exce_i) begin
          epc_q     <= instr_addr_i;
          cause_q   <= ecall_exce_i ? MCAUSE_ECALL : MCAUSE_EBREAK;
          mstatus_q <= mstatus_i;
          state_q   <= SAVE_MEPC;
        end
        SAVE_MEPC:    state_q <= SAVE_MCAUSE;
        SAVE_MCAUSE:  state_q <= SAVE_MSTATUS;
        SAVE_MSTATUS: state_q <= REDIRECT;
        default:      state_q <= IDLE;
      endcase
    end
  end
  // outputs are gated by rst_i so they read 0 for the whole time reset is held
  always_comb begin
    idle      = (state_q == IDLE) && !rst_i;
    exc       = ecall_exce_i || ebreak_exce_i;
    trap_go   = idle && exc;
    mret_go   = idle && !exc && mret_i;
    jump_go   = idle && !exc && !mret_i && jump_flag_i;
    s_mepc    = (state_q == SAVE_MEPC) && !rst_i;
    s_mcause  = (state_q == SAVE_MCAUSE) && !rst_i;
    s_mstatus = (state_q == SAVE_MSTATUS) && !rst_i;
    s_redir   = (state_q == REDIRECT) && !rst_i;
    save      = s_mepc || s_mcause || s_mstatus;
  end
  always_comb begin
    trap_mstatus = {mstatus_q[31:13], 2'b11, mstatus_q[10:8], mstatus_q[3], mstatus_q[6:4], 1'b0, mstatus_q[2:0]};
    mret_mstatus = {mstatus_i[31:13], 2'b11, mstatus_i[10:8], 1'b1, mstatus_i[6:4], mstatus_i[7], mstatus_i[2:0]};
  end
  always_comb begin
    csr_we_o        = save || mret_go;
    csr_waddr_o     = s_mepc ? 12'h341 : s_mcause ? 12'h342 : (s_mstatus || mret_go) ? 12'h300 : 12'h000;
    csr_wdata_o     = s_mepc ? epc_q : s_mcause ? cause_q : s_mstatus ? trap_mstatus : mret_go ? mret_mstatus : 32'd0;
    refresh_pip_o   = trap_go || save || s_redir || mret_go || jump_go;
    stall_o         = trap_go || save || (idle && stallreq_i && !(mret_go || jump_go));
    redirect_o      = s_redir || mret_go || jump_go;
    redirect_addr_o = s_redir ? {mtvec_i[31:2], 2'b00} : mret_go ? mepc_i : jump_go ? jump_addr_i : 32'd0;
    trap_busy_o     = state_q != IDLE;
  end
endmodule
